alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 8-bit ALU between two requesters, e.g. the instruction datapath and an address/auxiliary unit. Each requester submits an operation with a valid/ready handshake. The arbiter grants one request at a time using round-robin priority, drives the ALU from registered operands, captures the result, and returns it on a per-requester response channel with valid/ready backpressure. Only one operation is in flight at a time.

## Interface
Parameters:
- DATA_W, 8, operand/result width; only 8 supported (ALU is fixed 8-bit)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  ALU op: 00 ADD, 01 SUB, 10 SLL, 11 AND
- req0_a  in  8  operand A
- req0_b  in  8  operand B (shift amount for SLL)
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_data  out  8  result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as requester 0
- alu_op  out  2  to ALU op input, registered
- alu_a  out  8  to ALU first source, registered
- alu_b  out  8  to ALU second source, registered
- alu_result  in  8  from ALU result (combinational)
- busy  out  1  high in EXEC or RESP
- grant_id  out  1  requester currently owning the ALU (valid when busy)

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Arbitration (IDLE only):
  - If exactly one req valid, select it.
  - If both are valid, select the requester that is not last_grant.
  - last_grant resets to 1, so req0 wins the first tie.
- reqN_ready = (state==IDLE) && (selected==N). It is combinational on both req valids. It is never high outside IDLE. At most one ready is high per cycle.
- Accept (IDLE, selected valid && ready):
  - Load alu_op/alu_a/alu_b from the selected request.
  - Set grant_id = N.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - ALU inputs are stable.
  - Capture alu_result into a result register.
  - Go to RESP.
- RESP:
  - rspN_valid = 1 for N = grant_id only.
  - rspN_data = captured result.
  - Hold valid and data stable until rspN_ready.
  - On rspN_valid && rspN_ready: go to IDLE and set last_grant = grant_id.
- rspN_data for the non-granted requester and outside RESP holds its last value. Only the valid signal qualifies it.
- ALU arithmetic is the ALU's own: modulo-256 ADD/SUB, SLL with B>=8 yields 0. The arbiter does not modify the result.
- New requests arriving while busy wait with valid held; nothing is queued internally.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state=IDLE, last_grant=1, grant_id=0, busy=0
  - alu_op=00, alu_a=00, alu_b=00
  - rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=00
  - req ready outputs follow IDLE rules after reset deasserts.
- Latency:
  - Accept at edge T.
  - EXEC during cycle T..T+1; result captured at edge T+1.
  - rspN_valid high from edge T+1.
- Throughput: with rsp_ready held high, 1 op per 3 cycles (IDLE, EXEC, RESP).
- Backpressure: RESP persists indefinitely; the other requester's ready stays 0 throughout.
- Simultaneous rsp handshake and new request: the new request cannot be accepted in the same cycle. It is accepted in the following IDLE cycle, with priority computed from the updated last_grant.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and rsp valids go low immediately.
- req op/operand changes while valid && !ready are permitted. The values sampled at the accept edge are used.

## Test plan
- Single op: req0 ADD a=05 b=03 → req0_ready 1 in that cycle; rsp0_valid after 2 edges with rsp0_data=08; rsp1_valid stays 0.
- Wrap and shift: req1 SUB a=03 b=05 → rsp1_data=FE. Then req1 SLL a=01 b=09 → rsp1_data=00.
- Tie and round-robin:
  - Stimulus: req0 SLL a=01 b=03 and req1 AND a=F0 b=3C, both valid from reset; all rsp_ready=1.
  - Required: req0 served first (rsp0_data=08), then req1 (rsp1_data=30).
  - Then a second simultaneous pair is served req0 first again, since last_grant=1.
- Backpressure: req0 ADD FF+01 with rsp0_ready=0 for 5 cycles and req1 valid throughout → rsp0_valid and rsp0_data=00 held stable; req1_ready=0 all 5 cycles. req1 is accepted one cycle after rsp0_ready rises.
- Reset mid-RESP: rst_n low while rsp0_valid=1 → rsp0_valid=0, busy=0 immediately. After release, the next req0 ADD 02+02 → rsp0_data=04.
- Random compare: 1000 random ops on both requesters with random ready stalls, checked against a reference model for result, ordering, and alternation under constant contention.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 8-bit ALU between two requesters.
// Round-robin arbitration in IDLE, one cycle of EXEC with registered ALU
// operands, then RESP holding the captured result until the owner takes it.
// Only one operation is ever in flight; waiting requesters hold their valid.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  // shared ALU
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  // status
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                last_grant_q;
  logic                sel;
  logic                sel_valid;
  logic                accept;
  logic                rsp_fire;

  // Operand stage (loaded at accept, drives the ALU during EXEC)
  logic [1:0]          op_p0;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic                grant_p0;

  // Result stage (captured at the end of EXEC, one register per requester)
  logic [DATA_W-1:0]   res0_p1;
  logic [DATA_W-1:0]   res1_p1;

  // Round-robin pick: a lone request wins; on a tie the one not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant_q;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
    sel_valid = sel ? req1_valid : req0_valid;
  end

  // Handshake decode: readies only in IDLE, responses only in RESP for the owner.
  always_comb begin
    accept     = (state_q == IDLE) && sel_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !sel;
    req1_ready = (state_q == IDLE) && req1_valid &&  sel;
    rsp0_valid = (state_q == RESP) && !grant_p0;
    rsp1_valid = (state_q == RESP) &&  grant_p0;
    rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  end

  // Next-state logic; a response handshake returns to IDLE without a same-cycle accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = EXEC;
      EXEC:                  state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin history, updated only when a response completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if ((state_q == RESP) && rsp_fire) begin
      last_grant_q <= grant_p0;
    end
  end

  // Accept -> EXEC: latch the selected request's op and operands plus its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0    <= 2'b00;
      a_p0     <= '0;
      b_p0     <= '0;
      grant_p0 <= 1'b0;
    end else if (accept) begin
      op_p0    <= sel ? req1_op : req0_op;
      a_p0     <= sel ? req1_a  : req0_a;
      b_p0     <= sel ? req1_b  : req0_b;
      grant_p0 <= sel;
    end
  end

  // EXEC -> RESP: capture the ALU result into the owner's response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res0_p1 <= '0;
      res1_p1 <= '0;
    end else if (state_q == EXEC) begin
      if (grant_p0) begin
        res1_p1 <= alu_result;
      end else begin
        res0_p1 <= alu_result;
      end
    end
  end

  assign alu_op    = op_p0;
  assign alu_a     = a_p0;
  assign alu_b     = b_p0;
  assign rsp0_data = res0_p1;
  assign rsp1_data = res1_p1;
  assign grant_id  = grant_p0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural 8-bit ALU.
module tb_alu_arbiter;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_a, req0_b, rsp0_data;
  logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_a, req1_b, rsp1_data;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       busy, grant_id;

  int compared   = 0;
  int mismatched = 0;
  logic m_last;

  logic [1:0] p_op [2];
  logic [7:0] p_a  [2];
  logic [7:0] p_b  [2];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
      default: return a & b;
    endcase
  endfunction

  // External ALU
  always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic next_neg();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE with requester 'id' expected to win.
  task automatic run_op(input int id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input int stalls);
    logic my_ready, oth_ready, my_valid, oth_valid;
    logic [7:0] my_data;
    #1;
    my_ready  = (id == 0) ? req0_ready : req1_ready;
    oth_ready = (id == 0) ? req1_ready : req0_ready;
    chk("idle_busy", busy, 1'b0);
    chk("winner_ready", my_ready, 1'b1);
    chk("loser_ready", oth_ready, 1'b0);
    next_neg();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (id == 0) rsp0_ready = (stalls == 0); else rsp1_ready = (stalls == 0);
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_grant", grant_id, id[0]);
    chk("exec_alu_op", alu_op, op);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_rsp_valids", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("exec_ready", {req1_ready, req0_ready}, 2'b00);
    next_neg();
    #1;
    for (int s = 0; s <= stalls; s++) begin
      my_valid  = (id == 0) ? rsp0_valid : rsp1_valid;
      oth_valid = (id == 0) ? rsp1_valid : rsp0_valid;
      my_data   = (id == 0) ? rsp0_data  : rsp1_data;
      chk("resp_valid", my_valid, 1'b1);
      chk("resp_data", my_data, exp);
      chk("resp_other_valid", oth_valid, 1'b0);
      chk("resp_ready", {req1_ready, req0_ready}, 2'b00);
      if (s < stalls) begin
        next_neg();
        if (s == stalls - 1) begin
          if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        end
        #1;
      end
    end
    next_neg();
    m_last = id[0];
    #1;
    my_valid = (id == 0) ? rsp0_valid : rsp1_valid;
    my_data  = (id == 0) ? rsp0_data  : rsp1_data;
    chk("done_busy", busy, 1'b0);
    chk("done_valid", my_valid, 1'b0);
    chk("done_data_held", my_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_a = 8'h00; req0_b = 8'h00; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = 8'h00; req1_b = 8'h00; rsp1_ready = 1'b0;
    m_last = 1'b1;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_alu", {alu_op, alu_a, alu_b}, 18'h0);
    chk("rst_rsp_valids", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("rst_rsp_data", {rsp1_data, rsp0_data}, 16'h0000);

    // Tie from reset: req0 wins first
    set_req(0, OP_SLL, 8'h01, 8'h03);
    set_req(1, OP_AND, 8'hF0, 8'h3C);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_op(0, OP_SLL, 8'h01, 8'h03, 8'h08, 0);
    run_op(1, OP_AND, 8'hF0, 8'h3C, 8'h30, 0);

    // Second simultaneous pair: req0 first again
    set_req(0, OP_ADD, 8'h10, 8'h20);
    set_req(1, OP_SUB, 8'h10, 8'h01);
    run_op(0, OP_ADD, 8'h10, 8'h20, 8'h30, 0);
    run_op(1, OP_SUB, 8'h10, 8'h01, 8'h0F, 0);

    // Single ops, wrap and shift
    set_req(0, OP_ADD, 8'h05, 8'h03);
    run_op(0, OP_ADD, 8'h05, 8'h03, 8'h08, 0);
    chk("single_rsp1_quiet", rsp1_valid, 1'b0);
    set_req(1, OP_SUB, 8'h03, 8'h05);
    run_op(1, OP_SUB, 8'h03, 8'h05, 8'hFE, 0);
    set_req(1, OP_SLL, 8'h01, 8'h09);
    run_op(1, OP_SLL, 8'h01, 8'h09, 8'h00, 0);

    // Backpressure: req0 held 5 cycles in RESP while req1 waits
    set_req(0, OP_ADD, 8'hFF, 8'h01);
    set_req(1, OP_AND, 8'hFF, 8'h0F);
    run_op(0, OP_ADD, 8'hFF, 8'h01, 8'h00, 5);
    run_op(1, OP_AND, 8'hFF, 8'h0F, 8'h0F, 0);

    // Reset mid-RESP
    set_req(0, OP_ADD, 8'h03, 8'h04);
    rsp0_ready = 1'b0;
    next_neg();
    req0_valid = 1'b0;
    next_neg();
    #1;
    chk("midrst_pre_valid", rsp0_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", rsp0_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    m_last = 1'b1;
    next_neg();
    rst_n = 1'b1;
    set_req(0, OP_ADD, 8'h02, 8'h02);
    run_op(0, OP_ADD, 8'h02, 8'h02, 8'h04, 0);

    // Random ops under constant contention with random response stalls
    for (int r = 0; r < 2; r++) begin
      p_op[r] = 2'($urandom_range(0, 3));
      p_a[r]  = 8'($urandom_range(0, 255));
      p_b[r]  = (p_op[r] == OP_SLL) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      set_req(r, p_op[r], p_a[r], p_b[r]);
    end
    for (int k = 0; k < 1000; k++) begin
      w = m_last ? 0 : 1;
      run_op(w, p_op[w], p_a[w], p_b[w], alu_ref(p_op[w], p_a[w], p_b[w]),
             ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
      p_op[w] = 2'($urandom_range(0, 3));
      p_a[w]  = 8'($urandom_range(0, 255));
      p_b[w]  = (p_op[w] == OP_SLL) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      set_req(w, p_op[w], p_a[w], p_b[w]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
